// File: rtl/sync_fifo_cfg.sv
// Single-clock FIFO with fill level, almost-full/almost-empty thresholds and registered or FWFT read.
// Optional sticky overflow/underflow outputs are enabled with SYNC_FIFO_ERR_STICKY_EN.
module sync_fifo_cfg #(
    parameter int DATASIZE  = 8,
    parameter int ADDRSIZE  = 4,
    parameter int AFULL_TH  = 2,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = 0
) (
    input  logic                CLK_I,
    input  logic                RST_I,
    input  logic [DATASIZE-1:0] WDATA_I,
    input  logic                WINC_I,
    input  logic                RINC_I,
    output logic [DATASIZE-1:0] RDATA_O,
    output logic                WFULL_O,
    output logic                AWFULL_O,
    output logic                REMPTY_O,
    output logic                AREMPTY_O,
`ifdef SYNC_FIFO_ERR_STICKY_EN
    output logic                OVF_O,
    output logic                UDF_O,
`endif
    output logic [ADDRSIZE:0]   COUNT_O
);

    localparam int DEPTH = 1 << ADDRSIZE;
    localparam logic [ADDRSIZE:0] DEPTH_C     = (ADDRSIZE+1)'(DEPTH);
    localparam logic [ADDRSIZE:0] AFULL_TH_C  = (ADDRSIZE+1)'(AFULL_TH);
    localparam logic [ADDRSIZE:0] AEMPTY_TH_C = (ADDRSIZE+1)'(AEMPTY_TH);

    generate
        if (AFULL_TH >= DEPTH || AEMPTY_TH >= DEPTH) begin : g_bad_threshold
            $error("sync_fifo_cfg: AFULL_TH and AEMPTY_TH must both be below DEPTH");
        end
    endgenerate

    logic [DATASIZE-1:0] mem [DEPTH];
    logic [ADDRSIZE:0]   wptr;
    logic [ADDRSIZE:0]   rptr;
    logic [ADDRSIZE:0]   wptr_next;
    logic [ADDRSIZE:0]   rptr_next;
    logic [ADDRSIZE:0]   count_next;
    logic [ADDRSIZE-1:0] waddr;
    logic [ADDRSIZE-1:0] raddr;
    logic                wr_ok;
    logic                rd_ok;

    assign waddr = wptr[ADDRSIZE-1:0];
    assign raddr = rptr[ADDRSIZE-1:0];

    // Accepts look only at registered flags, so a same-cycle read never frees room for a full write.
    assign wr_ok = WINC_I & ~WFULL_O;
    assign rd_ok = RINC_I & ~REMPTY_O;

    // Deriving the count from the pointer difference keeps it consistent with the wrap-bit view of full/empty.
    always_comb begin
        wptr_next  = wr_ok ? wptr + 1'b1 : wptr;
        rptr_next  = rd_ok ? rptr + 1'b1 : rptr;
        count_next = wptr_next - rptr_next;
    end

    always_ff @(posedge CLK_I) begin
        if (wr_ok) begin
            mem[waddr] <= WDATA_I;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            wptr      <= '0;
            rptr      <= '0;
            COUNT_O   <= '0;
            WFULL_O   <= 1'b0;
            AWFULL_O  <= 1'b0;
            REMPTY_O  <= 1'b1;
            AREMPTY_O <= 1'b1;
        end else begin
            wptr      <= wptr_next;
            rptr      <= rptr_next;
            COUNT_O   <= count_next;
            WFULL_O   <= (count_next == DEPTH_C);
            AWFULL_O  <= ((DEPTH_C - count_next) <= AFULL_TH_C);
            REMPTY_O  <= (count_next == '0);
            AREMPTY_O <= (count_next <= AEMPTY_TH_C);
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign RDATA_O = mem[raddr];
        end else begin : g_registered
            always_ff @(posedge CLK_I) begin
                if (RST_I) begin
                    RDATA_O <= '0;
                end else if (rd_ok) begin
                    RDATA_O <= mem[raddr];
                end
            end
        end
    endgenerate

`ifdef SYNC_FIFO_ERR_STICKY_EN
    // Sticky error flags record any rejected request until the next reset.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            OVF_O <= 1'b0;
            UDF_O <= 1'b0;
        end else begin
            if (WINC_I & WFULL_O) begin
                OVF_O <= 1'b1;
            end
            if (RINC_I & REMPTY_O) begin
                UDF_O <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_cfg.sv
// Bench driving a registered-read and an FWFT instance of sync_fifo_cfg with one shared stimulus stream,
// compared each cycle against a queue-based model of the FIFO.
module tb_sync_fifo_cfg;

    logic       clk;
    logic       rst;
    logic [7:0] wdata;
    logic       winc;
    logic       rinc;

    logic [7:0] rdata_reg, rdata_fwft;
    logic       wfull_reg, wfull_fwft;
    logic       awfull_reg, awfull_fwft;
    logic       rempty_reg, rempty_fwft;
    logic       arempty_reg, arempty_fwft;
    logic [2:0] count_reg, count_fwft;
`ifdef SYNC_FIFO_ERR_STICKY_EN
    logic       ovf_reg, ovf_fwft;
    logic       udf_reg, udf_fwft;
`endif

    int checks   = 0;
    int failures = 0;

    logic [7:0] model_q[$];
    logic [7:0] model_rdata;
    bit         model_ovf;
    bit         model_udf;

    sync_fifo_cfg #(.DATASIZE(8), .ADDRSIZE(2), .AFULL_TH(1), .AEMPTY_TH(1), .FWFT(0)) dut_reg (
        .CLK_I(clk), .RST_I(rst), .WDATA_I(wdata), .WINC_I(winc), .RINC_I(rinc),
        .RDATA_O(rdata_reg), .WFULL_O(wfull_reg), .AWFULL_O(awfull_reg),
        .REMPTY_O(rempty_reg), .AREMPTY_O(arempty_reg),
`ifdef SYNC_FIFO_ERR_STICKY_EN
        .OVF_O(ovf_reg), .UDF_O(udf_reg),
`endif
        .COUNT_O(count_reg)
    );

    sync_fifo_cfg #(.DATASIZE(8), .ADDRSIZE(2), .AFULL_TH(1), .AEMPTY_TH(1), .FWFT(1)) dut_fwft (
        .CLK_I(clk), .RST_I(rst), .WDATA_I(wdata), .WINC_I(winc), .RINC_I(rinc),
        .RDATA_O(rdata_fwft), .WFULL_O(wfull_fwft), .AWFULL_O(awfull_fwft),
        .REMPTY_O(rempty_fwft), .AREMPTY_O(arempty_fwft),
`ifdef SYNC_FIFO_ERR_STICKY_EN
        .OVF_O(ovf_fwft), .UDF_O(udf_fwft),
`endif
        .COUNT_O(count_fwft)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // One clock of stimulus: inputs set at the falling edge, model advanced for the coming rising edge,
    // outputs of both instances compared just after it.
    task automatic applyStimulus(input bit r, input bit w, input bit rd, input logic [7:0] d);
        bit full, empty;
        int n;
        @(negedge clk);
        rst   = r;
        winc  = w;
        rinc  = rd;
        wdata = d;
        if (r) begin
            model_q.delete();
            model_rdata = 8'h00;
            model_ovf   = 1'b0;
            model_udf   = 1'b0;
        end else begin
            full  = (model_q.size() == 4);
            empty = (model_q.size() == 0);
            if (w && full)   model_ovf = 1'b1;
            if (rd && empty) model_udf = 1'b1;
            if (rd && !empty) model_rdata = model_q.pop_front();
            if (w && !full)   model_q.push_back(d);
        end
        @(posedge clk);
        #1;
        n = model_q.size();
        checkOutput("count_reg",   32'(count_reg),   32'(n));
        checkOutput("count_fwft",  32'(count_fwft),  32'(n));
        checkOutput("empty_reg",   32'(rempty_reg),  32'(n == 0));
        checkOutput("empty_fwft",  32'(rempty_fwft), 32'(n == 0));
        checkOutput("full_reg",    32'(wfull_reg),   32'(n == 4));
        checkOutput("full_fwft",   32'(wfull_fwft),  32'(n == 4));
        checkOutput("afull_reg",   32'(awfull_reg),  32'((4 - n) <= 1));
        checkOutput("afull_fwft",  32'(awfull_fwft), 32'((4 - n) <= 1));
        checkOutput("aempty_reg",  32'(arempty_reg), 32'(n <= 1));
        checkOutput("aempty_fwft", 32'(arempty_fwft),32'(n <= 1));
        checkOutput("rdata_reg",   32'(rdata_reg),   32'(model_rdata));
        if (n > 0) begin
            checkOutput("rdata_fwft", 32'(rdata_fwft), 32'(model_q[0]));
        end
`ifdef SYNC_FIFO_ERR_STICKY_EN
        checkOutput("ovf_reg",  32'(ovf_reg),  32'(model_ovf));
        checkOutput("ovf_fwft", 32'(ovf_fwft), 32'(model_ovf));
        checkOutput("udf_reg",  32'(udf_reg),  32'(model_udf));
        checkOutput("udf_fwft", 32'(udf_fwft), 32'(model_udf));
`endif
    endtask

    initial begin
        logic [7:0] fill_data [5];
        logic [7:0] seq;
        rst   = 1'b0;
        winc  = 1'b0;
        rinc  = 1'b0;
        wdata = 8'h00;
        model_rdata = 8'h00;
        model_ovf   = 1'b0;
        model_udf   = 1'b0;
        fill_data = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        $display("[TB] reset and idle");
        applyStimulus(1, 0, 0, 8'h00);
        applyStimulus(0, 0, 0, 8'h00);
        checkOutput("reset_empty", 32'(rempty_reg), 32'd1);

        $display("[TB] fill past full");
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, fill_data[i]);
        checkOutput("fill_count", 32'(count_reg), 32'd4);
        checkOutput("fill_full",  32'(wfull_reg), 32'd1);

        $display("[TB] drain past empty");
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 8'h00);
        checkOutput("drain_hold", 32'(rdata_reg), 32'h44);

        $display("[TB] write to empty, fall-through");
        applyStimulus(0, 1, 0, 8'hA5);
        checkOutput("fwft_head", 32'(rdata_fwft), 32'hA5);
        applyStimulus(0, 0, 0, 8'h00);
        applyStimulus(0, 0, 1, 8'h00);

        $display("[TB] simultaneous read and write with wrap");
        applyStimulus(0, 1, 0, 8'h60);
        applyStimulus(0, 1, 0, 8'h61);
        seq = 8'h62;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 1, 1, seq);
            seq++;
        end
        checkOutput("simul_count", 32'(count_reg), 32'd2);

        $display("[TB] reset mid-operation with a write");
        applyStimulus(0, 1, 0, 8'h70);
        applyStimulus(1, 1, 0, 8'h71);
        checkOutput("midrst_count", 32'(count_reg), 32'd0);
        applyStimulus(0, 0, 0, 8'h00);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 79) == 0),
                          ($urandom_range(0, 99) < 55),
                          ($urandom_range(0, 99) < 50),
                          8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_fifo_cfg.md
Name: sync_fifo_cfg

Overview:
Single-clock, parametrised FIFO that succeeds the dual-clock FIFO top for blocks where producer and consumer share one clock. The Gray-code pointer synchronisers are dropped. It adds a runtime-visible fill level, programmable almost-full and almost-empty thresholds, and a selectable read mode: registered-output or first-word-fall-through (FWFT). Storage is a flop or inferred-RAM array of 2**ADDRSIZE words.

Parameters:
DATASIZE, 8, word width in bits (≥1)
ADDRSIZE, 4, address bits; depth DEPTH = 2**ADDRSIZE (≥1)
AFULL_TH, 2, AWFULL_O asserts when free slots ≤ AFULL_TH (0..DEPTH-1)
AEMPTY_TH, 2, AREMPTY_O asserts when stored words ≤ AEMPTY_TH (0..DEPTH-1)
FWFT, 0, 0 = registered read (1-cycle latency); 1 = first-word-fall-through

Ports:
CLK_I  in  1  single clock; all logic on rising edge
RST_I  in  1  synchronous reset, active-high
WDATA_I  in  DATASIZE  write data
WINC_I  in  1  write request
RINC_I  in  1  read request
RDATA_O  out  DATASIZE  read data
WFULL_O  out  1  FIFO holds DEPTH words
AWFULL_O  out  1  almost full
REMPTY_O  out  1  FIFO holds 0 words
AREMPTY_O  out  1  almost empty
COUNT_O  out  ADDRSIZE+1  words stored, 0..DEPTH

Behaviour:
- Interface: one clock (CLK_I); reset is synchronous and active-high (RST_I).
- Reset, sampled on the CLK_I edge with RST_I=1:
  - wptr, rptr and COUNT_O go to 0.
  - REMPTY_O=1, AREMPTY_O=1, WFULL_O=0, AWFULL_O=0.
  - RDATA_O=0 in registered mode.
  - Memory contents are not cleared.
  - Reset overrides WINC_I and RINC_I in the same cycle. A mid-operation reset discards all stored words.
- Pointers are ADDRSIZE+1 bits, binary. The address is the low ADDRSIZE bits. The MSB is the wrap bit; pointers wrap modulo 2*DEPTH.
- Write accept: wr_ok = WINC_I & !WFULL_O. On wr_ok, mem[waddr] <= WDATA_I and wptr increments.
- Read accept: rd_ok = RINC_I & !REMPTY_O. On rd_ok, rptr increments.
- Flags use registered state only. A read in the same cycle does not make room for a write while full. A write in the same cycle does not satisfy a read while empty.
- COUNT_O next value:
  - +1 on wr_ok & !rd_ok
  - −1 on rd_ok & !wr_ok
  - unchanged otherwise, including simultaneous accepts.
- All flags are registered and derived from the next COUNT_O value, so they update on the same edge as COUNT_O:
  - WFULL_O = (count == DEPTH)
  - REMPTY_O = (count == 0)
  - AWFULL_O = (DEPTH − count ≤ AFULL_TH)
  - AREMPTY_O = (count ≤ AEMPTY_TH)
- Full/empty equivalence: WFULL_O is equivalent to equal addresses with differing MSBs; REMPTY_O to fully equal pointers. Implementation must keep COUNT_O consistent with this.
- Registered mode (FWFT=0):
  - On rd_ok, RDATA_O <= mem[raddr] at that edge; valid one cycle after RINC_I is accepted.
  - RDATA_O holds its value when there is no rd_ok.
- FWFT mode (FWFT=1):
  - RDATA_O = mem[raddr] combinationally. The head word is valid whenever REMPTY_O=0.
  - rd_ok pops the head; the next word appears after the same edge.
  - When the FIFO is empty, RDATA_O is don't-care.
- Write-to-empty latency: a write accepted at edge N gives REMPTY_O=0 after edge N, in both modes.
- Write and read to the same address in one cycle cannot occur, because the FIFO is not empty when rd_ok fires. The memory needs no bypass.
- Parameter check: an elaboration-time assertion fires if AFULL_TH ≥ DEPTH or AEMPTY_TH ≥ DEPTH.

Optional Feature:
Macro SYNC_FIFO_ERR_STICKY_EN. When defined, two extra outputs are added:
- OVF_O (1 bit): set on WINC_I & WFULL_O.
- UDF_O (1 bit): set on RINC_I & REMPTY_O.
Both are sticky until RST_I, reset to 0, and are registered (assert the cycle after the offending request). Rejected requests still leave pointers and data unchanged. When undefined, the ports and logic are absent and rejected requests are silently ignored.

Test Plan (DATASIZE=8, ADDRSIZE=2, AFULL_TH=1, AEMPTY_TH=1):
- Reset, then idle: after the reset edge, COUNT_O=0, REMPTY_O=1, AREMPTY_O=1, WFULL_O=0, AWFULL_O=0.
- Fill: write 0x11, 0x22, 0x33, 0x44, then a 5th write of 0x55.
  - AWFULL_O=1 once COUNT_O=3.
  - WFULL_O=1 once COUNT_O=4.
  - 0x55 is dropped; COUNT_O stays 4.
  - With SYNC_FIFO_ERR_STICKY_EN, OVF_O=1 next cycle.
- Drain, FWFT=0: read 4 times. RDATA_O = 0x11, 0x22, 0x33, 0x44, each one cycle after its accepted read. REMPTY_O=1 after the 4th. A 5th read leaves RDATA_O at 0x44 (and sets UDF_O).
- FWFT=1: write 0xA5 into the empty FIFO. Next cycle REMPTY_O=0 and RDATA_O=0xA5 with no read issued. One read gives REMPTY_O=1.
- Simultaneous: with COUNT_O=2, assert WINC_I and RINC_I for 6 cycles with incrementing data. COUNT_O stays 2, pointers wrap, and read data is in order with no loss.
- Reset mid-operation: with COUNT_O=3, assert RST_I together with WINC_I. Next cycle COUNT_O=0, REMPTY_O=1, and the write is discarded.
